// File: rtl/barrier_sprite_gen.sv
// Perspective barrier sprite: advances toward the player once per frame, widens with depth,
// and produces registered per-pixel colour/hit plus a collision-window flag.
module barrier_sprite_gen #(
    parameter int SIDE     = 1,
    parameter int START_X  = 680,
    parameter int START_Y  = 360,
    parameter int END_Y    = 720,
    parameter int STEP_X   = 10,
    parameter int STEP_Y   = 10,
    parameter int STR_Y1   = 440,
    parameter int STR_Y2   = 550,
    parameter int HIT_Y_LO = 600,
    parameter int HIT_Y_HI = 639
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_v_sync,
    input  logic        i_active,
    input  logic        i_pause,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_sprite_hit,
    output logic        o_in_position,
    output logic        o_done
);

    // state   | meaning
    // IDLE    | parked at start position, sprite hidden
    // ADVANCE | scrolling toward player, outside collision window
    // HIT_WIN | scrolling, y inside collision window
    // PASSED  | reached END_Y, holding position, still visible
    typedef enum logic [1:0] {IDLE, ADVANCE, HIT_WIN, PASSED} state_t;

    localparam logic [15:0] L_START_X  = 16'(START_X);
    localparam logic [15:0] L_START_Y  = 16'(START_Y);
    localparam logic [15:0] L_END_Y    = 16'(END_Y);
    localparam logic [15:0] L_STEP_X   = 16'(STEP_X);
    localparam logic [15:0] L_STR_Y1   = 16'(STR_Y1);
    localparam logic [15:0] L_STR_Y2   = 16'(STR_Y2);
    localparam logic [15:0] L_HIT_Y_LO = 16'(HIT_Y_LO);
    localparam logic [15:0] L_HIT_Y_HI = 16'(HIT_Y_HI);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [2:0]  shift_q, shift_d;
    logic        v_sync_q;
    logic        done_q, done_d;
    logic        hit_q, hit_d;
    logic [23:0] rgb_q, rgb_d;

    logic        tick;
    logic [16:0] y_sum, x_sum;
    logic [15:0] y_n, x_n;
    logic [2:0]  shift_n;

    assign tick = i_v_sync & ~v_sync_q;

    always_comb begin
        y_sum = {1'b0, y_q} + 17'(STEP_Y);
        x_sum = {1'b0, x_q} + 17'(STEP_X);
        y_n   = (y_sum >= 17'(END_Y)) ? L_END_Y : y_sum[15:0];
        if (SIDE != 0) begin
            x_n = x_sum[16] ? 16'hFFFF : x_sum[15:0];
        end else begin
            x_n = (x_q < L_STEP_X) ? 16'h0000 : x_q - L_STEP_X;
        end
        if (y_n >= L_STR_Y2) begin
            shift_n = 3'd4;
        end else if (y_n >= L_STR_Y1) begin
            shift_n = 3'd3;
        end else begin
            shift_n = 3'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (i_active) state_d = ADVANCE;
            end
            ADVANCE, HIT_WIN: begin
                if (tick && !i_pause) begin
                    x_d     = x_n;
                    y_d     = y_n;
                    shift_d = shift_n;
                    if (y_n == L_END_Y) begin
                        state_d = PASSED;
                    end else if (y_n >= L_HIT_Y_LO && y_n <= L_HIT_Y_HI) begin
                        state_d = HIT_WIN;
                    end else begin
                        state_d = ADVANCE;
                    end
                end
            end
            PASSED: begin
                state_d = PASSED;
            end
            default: state_d = IDLE;
        endcase
        if (!i_active) begin
            state_d = IDLE;
            x_d     = L_START_X;
            y_d     = L_START_Y;
            shift_d = 3'd2;
        end
        done_d = (state_d == PASSED) && (state_q != PASSED);
    end

    // Pixel path; 17-bit differences wrap negative offsets above any width, so one compare suffices.
    logic [16:0] dx, dy, width;
    logic        hx, hy, vis;
    logic [3:0]  col;
    logic [2:0]  row;
    logic [31:0] rom_row;
    logic [1:0]  idx;

    always_comb begin
        dx    = {1'b0, i_x} - {1'b0, x_q};
        dy    = {1'b0, i_y} - {1'b0, y_q};
        width = 17'd16 << shift_q;
        hx    = dx < width;
        hy    = dy < 17'd32;
        row   = dy[4:2];
        case (shift_q)
            3'd3:    col = dx[6:3];
            3'd4:    col = dx[7:4];
            default: col = dx[5:2];
        endcase
        case (row)
            3'd3, 3'd4, 3'd5, 3'd6: rom_row = 32'h5555_5555;
            default:                rom_row = 32'h0000_0000;
        endcase
        idx   = rom_row[{col, 1'b0} +: 2];
        vis   = hx && hy && (state_q != IDLE);
        hit_d = vis && (idx != 2'd0);
        rgb_d = 24'h000000;
        if (vis) begin
            case (idx)
                2'd1:    rgb_d = 24'hFF0000;
                2'd2:    rgb_d = 24'h8ED8ED;
                2'd3:    rgb_d = 24'hFFFFFF;
                default: rgb_d = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            x_q      <= L_START_X;
            y_q      <= L_START_Y;
            shift_q  <= 3'd2;
            v_sync_q <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            rgb_q    <= 24'h000000;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            shift_q  <= shift_d;
            v_sync_q <= i_v_sync;
            done_q   <= done_d;
            hit_q    <= hit_d;
            rgb_q    <= rgb_d;
        end
    end

    assign o_red         = rgb_q[23:16];
    assign o_green       = rgb_q[15:8];
    assign o_blue        = rgb_q[7:0];
    assign o_sprite_hit  = hit_q;
    assign o_in_position = (state_q == HIT_WIN);
    assign o_done        = done_q;

endmodule
